// File: rtl/st_reg_pkg.sv
// Shared definitions for the envelope-state register bank: word layout,
// default initial value and controller state encoding.
package st_reg_pkg;

  localparam int LEVEL_W    = 32;
  localparam int OLDLEVEL_W = 32;
  localparam int DISTANCE_W = 32;
  localparam int ST_W       = 11;

  // Word layout, LSB first: {level, oldlevel, distance, st}
  localparam int ST_LSB       = 0;
  localparam int DISTANCE_LSB = ST_LSB + ST_W;
  localparam int OLDLEVEL_LSB = DISTANCE_LSB + DISTANCE_W;
  localparam int LEVEL_LSB    = OLDLEVEL_LSB + OLDLEVEL_W;
  localparam int STATE_W      = LEVEL_LSB + LEVEL_W;

  localparam logic [STATE_W-1:0] INIT_VAL_DEF = '0;

  typedef enum logic [1:0] {
    S_INIT = 2'd0,
    S_IDLE = 2'd1,
    S_CLRV = 2'd2
  } bank_state_e;

  function automatic logic [STATE_W-1:0] pack_state(
    input logic [LEVEL_W-1:0]    level,
    input logic [OLDLEVEL_W-1:0] oldlevel,
    input logic [DISTANCE_W-1:0] distance,
    input logic [ST_W-1:0]       st
  );
    return {level, oldlevel, distance, st};
  endfunction

endpackage

// File: rtl/st_reg_bank_if.sv
// Access bus of the envelope-state bank: write/read ports, read return,
// init status and the per-voice clear handshake.
interface st_reg_bank_if #(
  parameter int DATA_W  = 107,
  parameter int AW      = 6,
  parameter int V_WIDTH = 3
);
  logic [DATA_W-1:0]  d;
  logic [AW-1:0]      write_address;
  logic               we;
  logic [AW-1:0]      read_address;
  logic               re;
  logic [DATA_W-1:0]  q;
  logic               q_valid;
  logic               init_busy;
  logic               clr_req;
  logic [V_WIDTH-1:0] clr_voice;
  logic               clr_ack;

  modport master (
    output d, write_address, we, read_address, re, clr_req, clr_voice,
    input  q, q_valid, init_busy, clr_ack
  );

  modport slave (
    input  d, write_address, we, read_address, re, clr_req, clr_voice,
    output q, q_valid, init_busy, clr_ack
  );
endinterface

// File: rtl/st_reg_sdp_ram.sv
// Simple dual-port storage array: one write port, one registered read port,
// no reset so it maps onto block RAM. Read-during-write returns old data.
module st_reg_sdp_ram #(
  parameter int DATA_W = 107,
  parameter int DEPTH  = 64,
  parameter int AW     = 6
) (
  input  logic              clk_i,
  input  logic              we_i,
  input  logic [AW-1:0]     waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic              re_i,
  input  logic [AW-1:0]     raddr_i,
  output logic [DATA_W-1:0] rdata_o
);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] rdata_q;

  always_ff @(posedge clk_i) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
    if (re_i) rdata_q <= mem_q[raddr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/st_reg_bank.sv
// Envelope-state register bank: post-reset init sweep, per-voice clear and a
// two-cycle pipelined read port with same-cycle write forwarding.
//
// state  | meaning
// S_INIT | sweep INIT_VAL over every address, external access ignored
// S_IDLE | external reads/writes; accepts a clear request
// S_CLRV | sweep INIT_VAL over one voice, stalled by external writes
module st_reg_bank
  import st_reg_pkg::*;
#(
  parameter int                VOICES   = 8,
  parameter int                V_ENVS   = 8,
  parameter int                V_WIDTH  = 3,
  parameter int                E_WIDTH  = 3,
  parameter int                DATA_W   = STATE_W,
  parameter logic [DATA_W-1:0] INIT_VAL = INIT_VAL_DEF
) (
  input  logic          sCLK_XVXENVS,
  input  logic          reset_reg_N,
  st_reg_bank_if.slave  bus
);

  localparam int                AW       = V_WIDTH + E_WIDTH;
  localparam int                DEPTH    = VOICES * V_ENVS;
  localparam logic [AW-1:0]     PTR_LAST = AW'(DEPTH - 1);
  localparam logic [E_WIDTH-1:0] ENV_LAST = E_WIDTH'(V_ENVS - 1);
  localparam logic [AW:0]       DEPTH_X  = (AW+1)'(DEPTH);

  bank_state_e        state_q, state_d;
  logic [AW-1:0]      ptr_q, ptr_d;
  logic [E_WIDTH-1:0] env_q, env_d;
  logic [V_WIDTH-1:0] voice_q, voice_d;
  logic               clr_ack_q, clr_ack_d;

  logic               ram_we_raw, ram_we;
  logic [AW-1:0]      ram_waddr;
  logic [DATA_W-1:0]  ram_wdata;
  logic [DATA_W-1:0]  ram_rdata;

  logic               rd_en, rd_oor, rd_byp, wr_ok;
  logic               re_q, oor_q, byp_q, q_valid_q;
  logic [DATA_W-1:0]  byp_data_q, q_q;

  assign wr_ok  = bus.we & ({1'b0, bus.write_address} < DEPTH_X);
  assign rd_oor = ({1'b0, bus.read_address} >= DEPTH_X);
  assign rd_en  = bus.re & (state_q != S_INIT);

  always_ff @(posedge sCLK_XVXENVS or negedge reset_reg_N) begin
    if (!reset_reg_N) begin
      state_q   <= S_INIT;
      ptr_q     <= '0;
      env_q     <= '0;
      voice_q   <= '0;
      clr_ack_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      env_q     <= env_d;
      voice_q   <= voice_d;
      clr_ack_q <= clr_ack_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    env_d      = env_q;
    voice_d    = voice_q;
    clr_ack_d  = 1'b0;
    ram_we_raw = 1'b0;
    ram_waddr  = ptr_q;
    ram_wdata  = INIT_VAL;
    case (state_q)
      S_INIT: begin
        ram_we_raw = 1'b1;
        if (ptr_q == PTR_LAST) begin
          ptr_d   = '0;
          state_d = S_IDLE;
        end else begin
          ptr_d = ptr_q + AW'(1);
        end
      end
      S_IDLE: begin
        ram_we_raw = wr_ok;
        ram_waddr  = bus.write_address;
        ram_wdata  = bus.d;
        // The ack cycle itself never starts a new clear; the requester is
        // still dropping its request then.
        if (bus.clr_req && !clr_ack_q) begin
          voice_d = bus.clr_voice;
          env_d   = '0;
          state_d = S_CLRV;
        end
      end
      S_CLRV: begin
        if (bus.we) begin
          ram_we_raw = wr_ok;
          ram_waddr  = bus.write_address;
          ram_wdata  = bus.d;
        end else begin
          ram_we_raw = 1'b1;
          ram_waddr  = {voice_q, env_q};
          if (env_q == ENV_LAST) begin
            state_d   = S_IDLE;
            clr_ack_d = 1'b1;
          end else begin
            env_d = env_q + E_WIDTH'(1);
          end
        end
      end
      default: state_d = S_INIT;
    endcase
  end

  // A sweep of an unpopulated voice must not reach past the array.
  assign ram_we = ram_we_raw & ({1'b0, ram_waddr} < DEPTH_X);

  // The array read happens in the cycle of the request, so a write landing
  // on the same address in that cycle is forwarded instead.
  assign rd_byp = rd_en & ram_we & (ram_waddr == bus.read_address);

  st_reg_sdp_ram #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .AW     (AW)
  ) u_ram (
    .clk_i   (sCLK_XVXENVS),
    .we_i    (ram_we),
    .waddr_i (ram_waddr),
    .wdata_i (ram_wdata),
    .re_i    (rd_en & ~rd_oor),
    .raddr_i (bus.read_address),
    .rdata_o (ram_rdata)
  );

  always_ff @(posedge sCLK_XVXENVS or negedge reset_reg_N) begin
    if (!reset_reg_N) begin
      re_q       <= 1'b0;
      oor_q      <= 1'b0;
      byp_q      <= 1'b0;
      byp_data_q <= '0;
      q_valid_q  <= 1'b0;
      q_q        <= '0;
    end else begin
      re_q      <= rd_en;
      oor_q     <= rd_oor;
      byp_q     <= rd_byp;
      if (rd_byp) byp_data_q <= ram_wdata;
      q_valid_q <= re_q;
      if (re_q) q_q <= oor_q ? INIT_VAL : (byp_q ? byp_data_q : ram_rdata);
    end
  end

  assign bus.q         = q_q;
  assign bus.q_valid   = q_valid_q;
  assign bus.init_busy = (state_q == S_INIT);
  assign bus.clr_ack   = clr_ack_q;

endmodule

// File: doc/st_reg_bank.md
Name: st_reg_bank

Overview:
Parametrised single-clock envelope-state register bank: one word per (voice, envelope), holding level, oldlevel, distance and st.
Sits between the envelope-generator pipeline and its state storage, in the sCLK_XVXENVS domain.
Adds a post-reset initialisation sweep and a per-voice clear, so storage is never read uninitialised and a retriggered voice starts from INIT_VAL.
The storage array itself has no reset.

Parameters:
VOICES, 8, number of voices
V_ENVS, 8, envelopes per voice
V_WIDTH, 3, voice index width (clog2 VOICES)
E_WIDTH, 3, envelope index width (clog2 V_ENVS)
DATA_W, 107, state word width {level, oldlevel, distance, st}
INIT_VAL, 0 (DATA_W bits), value written by init sweep and voice clear

Ports:
sCLK_XVXENVS  in  1  sole clock
reset_reg_N  in  1  asynchronous active-low reset
d  in  DATA_W  write data
write_address  in  V_WIDTH+E_WIDTH  write address {voice, env}
we  in  1  write enable
read_address  in  V_WIDTH+E_WIDTH  read address {voice, env}
re  in  1  read enable
q  out  DATA_W  read data
q_valid  out  1  q updated this cycle
init_busy  out  1  init sweep running; external access ignored
clr_req  in  1  request to clear one voice (level-held until clr_ack)
clr_voice  in  V_WIDTH  voice to clear, sampled when the request is accepted
clr_ack  out  1  one-cycle pulse when the clear completes

Behaviour:
- DEPTH = VOICES*V_ENVS. Address = {voice, env}, voice in the MSBs.
- Reset values while reset_reg_N=0: q=0, q_valid=0, init_busy=1, clr_ack=0, state=INIT, sweep pointer=0.
- Reset asserted mid-operation aborts everything and restarts INIT after release.
- FSM states: INIT, IDLE, CLRV.
- INIT:
  - Writes INIT_VAL to address ptr on each cycle, ptr 0..DEPTH-1; the sweep takes exactly DEPTH cycles.
  - init_busy=1 throughout. External we and re are ignored; q_valid stays 0.
  - After the write to DEPTH-1: go to IDLE with init_busy=0 on the next cycle.
- IDLE:
  - If clr_req=1: latch clr_voice, ptr_env=0, go to CLRV. clr_req is not accepted in INIT.
- CLRV:
  - Writes INIT_VAL to {latched voice, ptr_env}.
  - An external we in the same cycle has priority: the sweep stalls that cycle and ptr_env does not advance. The external write lands, even to an address already cleared.
  - After the write to ptr_env=V_ENVS-1: clr_ack=1 for one cycle, return to IDLE.
  - Requester must drop clr_req on clr_ack. clr_req still high the cycle after clr_ack starts a new clear.
- Reads:
  - re sampled with read_address at cycle N gives q and q_valid=1 at cycle N+2 (2-cycle latency: registered address, then registered data).
  - Fully pipelined: one read per cycle.
  - q holds its last value when no read completes; q_valid=0 on those cycles.
- Write/read ordering:
  - A read issued in cycle N returns data including every write (external or sweep) issued in any cycle ≤ N.
  - A write issued in cycle N+1 or later is not visible to that read.
  - Same-address write and read in the same cycle N: the read returns the new d.
- Writes: external we commits to the address presented in the same cycle. No width conversion; d is stored verbatim.
- Address ≥ DEPTH (non-power-of-two VOICES or V_ENVS): write dropped, read returns INIT_VAL with q_valid=1.

Decomposition:
- Package st_reg_pkg holds:
  - field widths and offsets for level, oldlevel, distance, st (sum = DATA_W)
  - default INIT_VAL
  - FSM state enum {INIT, IDLE, CLRV}
- Sub-module st_reg_sdp_ram: plain simple-dual-port array, DATA_W x DEPTH, one write port, registered read, no reset, block-RAM inferrable.
- Parent st_reg_bank owns the FSM, the write-port mux (external/sweep), the ordering/bypass compare, and the q_valid pipeline.

Test Plan:
- Release reset, re=1 at address 0 during INIT -> init_busy=1 for exactly 64 cycles, q_valid=0 throughout; first read after init_busy falls returns INIT_VAL with q_valid=1 two cycles later.
- Write d=107'h5A5 to address 9, then read address 9 in the next cycle -> q=107'h5A5 at read cycle+2. Same-cycle write and read of address 12 with d=0x3 -> q=0x3.
- Fill all 64 addresses with value=address, then clr_req with clr_voice=2 -> clr_ack after 8 cycles; addresses 16..23 read 0, addresses 15 and 24 still read 15 and 24.
- During CLRV of voice 2, external we to address 17 with d=0x77 on the 3rd sweep cycle -> sweep takes 9 cycles; 17 reads 0x77 if it was already swept, else 0.
- Back-to-back reads of addresses 0..63 with re=1 every cycle -> 64 consecutive q_valid pulses, data in order, no bubbles.
- Assert reset_reg_N=0 mid-CLRV -> q=0, q_valid=0 and clr_ack=0 immediately; after release a full 64-cycle INIT runs and every address reads INIT_VAL.
